// File: rtl/rr_arb8_if.sv
// rtl/rr_arb8_if.sv - request/grant bundle between requesters and rr_arb8
// Arbiter side uses the slave modport; the requester side uses master.
interface rr_arb8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output busy,
    output timeout
  );

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/rr_arb8.sv
// rtl/rr_arb8.sv - eight-way round-robin arbiter with registered one-hot grant
// Optional forced release after TIMEOUT_CYCLES is enabled by defining ARB_TIMEOUT_EN.
module rr_arb8 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic     clk,
  input  logic     rst,
  rr_arb8_if.slave bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [2:0] r_gnt_idx, w_gnt_idx_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic       r_busy, w_busy_nxt;
  logic [2:0] w_winner;
  logic [2:0] w_cand;
  logic       w_found;
  logic       w_release;
  logic       w_expire;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_arb8: TIMEOUT_CYCLES must be in 1..255");
  end

  // First requester at or after the pointer, wrapping mod 8.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int i = 0; i < 8; i++) begin
      w_cand = r_ptr + 3'(i);
      if (!w_found && bus.req[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  assign w_release = bus.done || !bus.req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold;
  logic       r_timeout;

  assign w_expire = (r_hold == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) r_hold <= '0;
      else if (r_state == S_GRANT)       r_hold <= r_hold + 8'd1;
      // A same-edge done counts as a normal release, so no pulse then.
      r_timeout <= (r_state == S_GRANT) && w_expire && !w_release;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_expire    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_idx_nxt = r_gnt_idx;
    w_gnt_nxt     = r_gnt;
    w_busy_nxt    = r_busy;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt   = S_GRANT;
          w_gnt_idx_nxt = w_winner;
          w_gnt_nxt     = 8'd1 << w_winner;
          w_busy_nxt    = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_release || w_expire) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = r_gnt_idx + 3'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_gnt     <= w_gnt_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_rr_arb8.sv
// tb/tb_rr_arb8.sv - scoreboard bench for rr_arb8
// Stimulus queues expected winners; a negedge monitor pops them on each new grant.
module tb_rr_arb8;
  logic clk = 1'b0;
  logic rst;

  rr_arb8_if bus();

  rr_arb8 #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!bus.busy && n < 20) begin
      step();
      n++;
    end
    check("wait_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic release_done();
    bus.done = 1'b1;
    step();
    check("release_latency", 32'(bus.busy), 32'd0);
    check("release_gnt", 32'(bus.gnt), 32'd0);
    bus.done = 1'b0;
  endtask

  // Monitor: invariants every cycle, winner compared at each grant entry.
  always @(negedge clk) begin
    logic [2:0] e;
    logic [7:0] dec;
    dec = bus.busy ? (8'd1 << bus.gnt_idx) : 8'd0;
    check("onehot_gnt", 32'(bus.gnt), 32'(dec));
`ifndef ARB_TIMEOUT_EN
    check("timeout_tied", 32'(bus.timeout), 32'd0);
`endif
    if (bus.busy && !prev_busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(bus.gnt_idx), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("grant_idx", 32'(bus.gnt_idx), 32'(e));
        check("grant_word", 32'(bus.gnt), 32'(8'd1 << e));
      end
    end
    prev_busy = bus.busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] busy_seq;
    logic [5:0] to_seq;
    rst      = 1'b1;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    step();
    step();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_idx", 32'(bus.gnt_idx), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);

    exp_q.push_back(3'd0);
    rst = 1'b0;
    step();
    check("first_grant_latency", 32'(bus.gnt), 32'h01);
    wait_busy();

    // Rotation with req = FF: 1..7 then wrap to 0.
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(3'(i % 8));
      release_done();
      wait_busy();
    end

    // Skip and wrap.
    bus.req = 8'h05;
    exp_q.push_back(3'd2);
    release_done();
    wait_busy();
    bus.req = 8'h84;
    exp_q.push_back(3'd7);
    release_done();
    wait_busy();
    exp_q.push_back(3'd2);
    release_done();
    wait_busy();
    exp_q.push_back(3'd7);
    release_done();
    wait_busy();

    // Owner drop.
    bus.req = 8'h20;
    exp_q.push_back(3'd5);
    release_done();
    wait_busy();
    bus.req = 8'h00;
    step();
    check("drop_release", 32'(bus.busy), 32'd0);
    exp_q.push_back(3'd6);
    bus.req = 8'h41;
    wait_busy();

    // Reset mid-grant.
    bus.req = 8'h10;
    exp_q.push_back(3'd4);
    release_done();
    wait_busy();
    check("mid_gnt", 32'(bus.gnt), 32'h10);
    rst     = 1'b1;
    bus.req = 8'hFF;
    step();
    check("midrst_gnt", 32'(bus.gnt), 32'd0);
    check("midrst_idx", 32'(bus.gnt_idx), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_timeout", 32'(bus.timeout), 32'd0);
    exp_q.push_back(3'd0);
    rst = 1'b0;
    wait_busy();
    bus.req = 8'h00;
    release_done();

`ifdef ARB_TIMEOUT_EN
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd0);
    bus.req = 8'h01;
    step();
    for (int k = 0; k < 6; k++) begin
      busy_seq[k] = bus.busy;
      to_seq[k]   = bus.timeout;
      step();
    end
    check("timeout_busy_seq", 32'(busy_seq), 32'b101111);
    check("timeout_pulse_seq", 32'(to_seq), 32'b010000);
    bus.req = 8'h00;
    step();
`else
    busy_seq = '0;
    to_seq   = '0;
    exp_q.push_back(3'd0);
    bus.req = 8'h01;
    step();
    for (int k = 0; k < 100; k++) begin
      check("hold_busy", 32'(bus.busy), 32'd1);
      check("hold_timeout", 32'(bus.timeout), 32'd0);
      step();
    end
    bus.req = 8'h00;
    step();
    check("hold_release", 32'(bus.busy), 32'd0);
`endif

    step();
    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rr_arb8.md
# rr_arb8

Eight-way round-robin arbiter that shares one resource among eight requesters and drives a one-hot grant through a 3-to-8 decode of the winning index. It is the sequencing layer above the combinational 3-to-8 decoder. The winner index goes out as a 3-bit code and the grant as the decoded 8-bit word. Each grant is held until the owner releases it, then the priority pointer advances.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 16: maximum grant hold length in cycles, range 1..255. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- req  input  8  request lines; bit i = requester i
- done  input  1  release strobe from the current owner
- gnt  output  8  one-hot grant; equals the 3-to-8 decode of gnt_idx while busy, else 0
- gnt_idx  output  3  winner index; MSB..LSB correspond to decoder inputs x,y,z
- busy  output  1  high while a grant is held
- timeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN

## Operation
- Two-state FSM: IDLE and GRANT. All outputs are registered.
- Internal 3-bit priority pointer ptr; reset value 0.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select the first set bit scanning ptr, ptr+1, … wrapping mod 8.
  - Register the winner into gnt_idx, set busy, drive gnt = 1 << winner, then go to GRANT.
- GRANT: a release occurs when done == 1, or when req[gnt_idx] == 0 (the owner dropped its request).
- On release:
  - gnt <= 0, busy <= 0.
  - ptr <= gnt_idx + 1, wrapping 7 -> 0.
  - Go to IDLE.
  - gnt_idx holds its last value.
- Requests from non-owners during GRANT have no effect on the current grant; they are evaluated in the next IDLE cycle.
- done asserted in IDLE is ignored.
- Invariants:
  - gnt is either 0 or has exactly one bit set.
  - gnt != 0 if and only if busy == 1.
- Reset in any state: FSM -> IDLE; gnt = 0, gnt_idx = 0, busy = 0, timeout = 0, ptr = 0, hold counter = 0. Reset takes priority over done and req on the same edge.

## Timing
- Grant latency: req sampled at edge k in IDLE -> gnt/busy valid after edge k (visible during cycle k+1).
- Release latency: done sampled high at edge m -> gnt = 0 and busy = 0 after edge m.
- Mandatory dead cycle: at least one IDLE cycle between consecutive grants.
  - The next grant appears no earlier than one cycle after busy falls.
  - Back-to-back service of 8 always-requesting clients therefore yields one grant every 2 cycles plus hold time.
- Fairness: a continuously requesting client waits at most 7 other grants before it is served.
- If done and the owner's req drop occur on the same edge, this is a single release: ptr advances once.

## Configuration
Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant entry and increments each GRANT cycle.
  - When the counter reaches TIMEOUT_CYCLES - 1 with no release, the next edge forces a release and timeout pulses high for exactly one cycle.
  - A forced release updates ptr the same way as a normal release.
  - If done arrives on the same edge the timeout would fire, it is a normal release and timeout stays 0.
  - The grant is therefore held for at most TIMEOUT_CYCLES cycles.
- Not defined: no counter is present, timeout is constant 0, and a grant is held indefinitely until done or the owner drops its request.

## Test plan
- Reset check: assert rst with req = 8'hFF, done = 0 -> gnt = 0, gnt_idx = 0, busy = 0, timeout = 0. Release rst -> gnt = 8'b0000_0001, gnt_idx = 3'b000 after one edge.
- Rotation: hold req = 8'hFF and pulse done one cycle after each grant -> gnt_idx sequence 0,1,2,…,7,0. Each gnt equals the 3-to-8 decode of gnt_idx, with one dead cycle between grants.
- Skip and wrap: req = 8'b1000_0100 with ptr = 3 -> grant 7; after release -> grant 2; after the next release -> grant 7.
- Owner drop: grant idx 5, then clear req[5] without done -> busy falls after that edge, ptr = 6. Set req = 8'b0100_0001 -> next grant idx 6.
- Reset mid-grant: while gnt = 8'b0001_0000, assert rst for one cycle -> all outputs 0, ptr = 0. With req = 8'hFF afterwards -> first grant idx 0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4): req = 8'h01, done held 0 -> busy high for exactly 4 cycles, timeout pulses once, then regrant to idx 0 after one IDLE cycle. Without the macro: busy stays high for 100 cycles and timeout stays 0.
